// File: rtl/register_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// register_arbiter_pkg
// Shared definitions for the register access arbiter:
//   - arb_state_e : sequencer states (IDLE -> ISSUE -> RESP -> IDLE)
//   - id_width()  : requester ID width for a given requester count (min 1 bit)
// -----------------------------------------------------------------------------
package register_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit ID so port widths stay legal.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selector: finds the first set request bit searching
// upward from ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  ID_W     search start position
//   grant  out NUM_REQ  one-hot winner (all zero when no request)
//   winner out ID_W     encoded winner (0 when no request)
//   any    out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker
  import register_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W-1:0] idx;
  logic            hit;

  // Walk the requesters in priority order starting at ptr; first hit wins.
  // NUM_REQ is a power of two, so ID_W-bit addition wraps exactly at NUM_REQ.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    hit    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx        = ptr + ID_W'(k);
      hit        = req[idx] & ~any;
      grant[idx] = hit;
      winner     = hit ? idx : winner;
      any        = any | hit;
    end
  end

endmodule

// File: rtl/register_access_arbiter.sv
// -----------------------------------------------------------------------------
// register_access_arbiter
// Shares one Register (separate read/write enables) among NUM_REQ requesters.
// One transaction at a time: grant (IDLE) -> enable pulse (ISSUE) -> response
// (RESP). Read and write enables are never asserted together; the Register's
// accessError is therefore only a safety monitor latched into err_sticky.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/write/data  per-requester request, op and write data slice
//   req_ready             one-hot combinational grant pulse (IDLE only)
//   rsp_valid/id/write    one-cycle completion with owner ID and op type
//   rsp_data              read: Register contents; write: echoed write data
//   busy                  transaction in flight
//   err_sticky            accessError ever observed since reset
//   reg_*                 connection to the shared Register
// All outputs are forced to their reset values while reset is asserted.
// -----------------------------------------------------------------------------
module register_access_arbiter
  import register_arbiter_pkg::*;
#(
  parameter  int N       = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ*N-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_write,
  output logic [N-1:0]         rsp_data,
  output logic                 busy,
  output logic                 err_sticky,
  output logic                 reg_write_enable,
  output logic                 reg_read_enable,
  output logic [N-1:0]         reg_data_in,
  input  logic [N-1:0]         reg_data_out,
  input  logic                 reg_access_error
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            write_q, write_d;
  logic [N-1:0]    data_q, data_d;
  logic            err_q, err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_winner;
  logic               pick_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Next-state logic: arbitrate in IDLE, then step through ISSUE and RESP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    write_d = write_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = ISSUE;
          id_d    = pick_winner;
          write_d = req_write[pick_winner];
          data_d  = req_data[int'(pick_winner)*N +: N];
          // Winner drops to lowest priority; wrap is implicit in ID_W bits.
          ptr_d   = pick_winner + {{(ID_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = err_q | reg_access_error;
  end

  // State, pointer, transaction latches and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      write_q <= write_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Output decode from state; reset masks everything so an aborted
  // transaction can neither pulse an enable nor emit a response.
  always_comb begin
    req_ready        = '0;
    rsp_valid        = 1'b0;
    rsp_id           = '0;
    rsp_write        = 1'b0;
    rsp_data         = '0;
    busy             = 1'b0;
    err_sticky       = 1'b0;
    reg_write_enable = 1'b0;
    reg_read_enable  = 1'b0;
    reg_data_in      = '0;
    if (reset) begin
      req_ready = '0;
    end else begin
      req_ready        = (state_q == IDLE) ? pick_grant : '0;
      busy             = (state_q != IDLE);
      rsp_valid        = (state_q == RESP);
      rsp_id           = id_q;
      rsp_write        = write_q;
      // Register dataOut was loaded at the edge ending ISSUE.
      rsp_data         = (state_q == RESP) ? (write_q ? data_q : reg_data_out) : '0;
      reg_write_enable = (state_q == ISSUE) &  write_q;
      reg_read_enable  = (state_q == ISSUE) & ~write_q;
      reg_data_in      = data_q;
      err_sticky       = err_q;
    end
  end

endmodule

// File: tb/tb_register_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_access_arbiter
// Randomised and directed stimulus against a transaction-level reference model
// (round-robin pointer, 3-cycle transaction occupancy, register contents).
// Expected responses are queued at grant time and popped by an independent
// monitor whenever rsp_valid appears. A behavioural Register sits on reg_*.
// -----------------------------------------------------------------------------
module tb_register_access_arbiter;

  localparam int N  = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk       = 1'b0;
  logic            reset     = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_write = '0;
  logic [NR*N-1:0] req_data  = '0;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic            rsp_write;
  logic [N-1:0]    rsp_data;
  logic            busy;
  logic            err_sticky;
  logic            reg_write_enable;
  logic            reg_read_enable;
  logic [N-1:0]    reg_data_in;
  logic [N-1:0]    reg_data_out;
  logic            reg_access_error;

  logic            force_err = 1'b0;
  logic [N-1:0]    reg_mem   = '0;
  logic [N-1:0]    reg_dout  = '0;

  register_access_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_id           (rsp_id),
    .rsp_write        (rsp_write),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .err_sticky       (err_sticky),
    .reg_write_enable (reg_write_enable),
    .reg_read_enable  (reg_read_enable),
    .reg_data_in      (reg_data_in),
    .reg_data_out     (reg_data_out),
    .reg_access_error (reg_access_error)
  );

  always #5 clk = ~clk;

  // Behavioural Register: dataOut loads on readEnable, contents on writeEnable.
  always @(posedge clk) begin
    if (reg_write_enable) reg_mem <= reg_data_in;
    if (reg_read_enable)  reg_dout <= reg_mem;
  end
  assign reg_data_out     = reg_dout;
  assign reg_access_error = (reg_write_enable & reg_read_enable) | force_err;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [IW-1:0] id;
    logic          wr;
    logic [N-1:0]  data;
    bit            chk_data;
    int            due;
  } rsp_t;
  rsp_t exp_q[$];

  // Reference model state
  int           ptr_m     = 0;
  int           busy_m    = 0;
  logic [N-1:0] mem_m     = '0;
  bit           mem_known = 1'b1;
  bit           err_m     = 1'b0;
  bit           pend[NR];
  bit           pwr[NR];
  logic [N-1:0] pdat[NR];
  bit           cont      = 1'b0;
  bit           force_req = 1'b0;
  int           iss_cyc   = -10;
  bit           iss_wr    = 1'b0;
  logic [N-1:0] iss_data  = '0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic new_req(input int i);
    pend[i] = 1'b1;
    pwr[i]  = ($urandom_range(0, 1) == 1);
    pdat[i] = $urandom;
  endtask

  // Reference model for one cycle: what the arbiter must show right now.
  task automatic model_eval(input bit rst);
    logic [NR-1:0] exp_ready;
    int            w;
    rsp_t          e;
    exp_ready = '0;
    w         = -1;
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_write", 64'(rsp_write), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_reg_data_in", 64'(reg_data_in), 64'(0));
      if (busy_m != 0) mem_known = 1'b0;
      ptr_m  = 0;
      busy_m = 0;
    end else begin
      if (busy_m > 0) begin
        chk("busy", 64'(busy), 64'(1));
        busy_m--;
      end else begin
        chk("busy", 64'(busy), 64'(0));
        for (int k = 0; k < NR; k++) begin
          if (w < 0 && pend[(ptr_m + k) % NR]) w = (ptr_m + k) % NR;
        end
        if (w >= 0) begin
          exp_ready[w] = 1'b1;
          e.id       = IW'(w);
          e.wr       = pwr[w];
          e.data     = pwr[w] ? pdat[w] : mem_m;
          e.chk_data = pwr[w] | mem_known;
          e.due      = cyc + 2;
          exp_q.push_back(e);
          iss_cyc  = cyc + 1;
          iss_wr   = pwr[w];
          iss_data = pdat[w];
          if (pwr[w]) begin
            mem_m     = pdat[w];
            mem_known = 1'b1;
          end
          ptr_m   = (w + 1) % NR;
          busy_m  = 2;
          pend[w] = 1'b0;
          if (cont) new_req(w);
        end
      end
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
    end
  endtask

  // One clock: drive inputs after the rising edge, evaluate at the falling edge.
  task automatic step(input bit rst);
    @(posedge clk);
    #1;
    reset     = rst;
    force_err = force_req;
    if (rst) begin
      exp_q.delete();
      iss_cyc = -10;
    end
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = pend[i];
      req_write[i]          = pwr[i];
      req_data[i*N +: N]    = pdat[i];
    end
    @(negedge clk);
    model_eval(rst);
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
  endtask

  task automatic drain();
    clear_pend();
    for (int i = 0; i < 4; i++) step(1'b0);
  endtask

  // Monitor: enables, sticky error and responses checked independently.
  always @(negedge clk) begin
    bit   exp_we;
    bit   exp_re;
    rsp_t h;
    exp_we = !reset && (cyc == iss_cyc) && iss_wr;
    exp_re = !reset && (cyc == iss_cyc) && !iss_wr;
    chk("reg_write_enable", 64'(reg_write_enable), 64'(exp_we));
    chk("reg_read_enable", 64'(reg_read_enable), 64'(exp_re));
    if (exp_we) chk("reg_data_in", 64'(reg_data_in), 64'(iss_data));
    chk("err_sticky", 64'(err_sticky), 64'(reset ? 1'b0 : err_m));
    if (reset) err_m = 1'b0;
    else if (reg_access_error) err_m = 1'b1;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: actual rsp_valid=1 id=%0d required no response (cycle %0d)", rsp_id, cyc);
      end else begin
        h = exp_q.pop_front();
        chk("rsp_latency_cycle", 64'(cyc), 64'(h.due));
        chk("rsp_id", 64'(rsp_id), 64'(h.id));
        chk("rsp_write", 64'(rsp_write), 64'(h.wr));
        if (h.chk_data) chk("rsp_data", 64'(rsp_data), 64'(h.data));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_rsp: actual rsp_valid=0 required response for id %0d (cycle %0d)", exp_q[0].id, cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      pwr[i]  = 1'b0;
      pdat[i] = '0;
    end

    // Reset with requests already pending: no grant may appear during reset.
    pend[1] = 1'b1;
    step(1'b1);
    step(1'b1);
    clear_pend();

    // Requester 2 writes 0xDEADBEEF, then requester 0 reads it back.
    pend[2] = 1'b1; pwr[2] = 1'b1; pdat[2] = 32'hDEADBEEF;
    for (int i = 0; i < 10 && pend[2]; i++) step(1'b0);
    drain();
    pend[0] = 1'b1; pwr[0] = 1'b0; pdat[0] = 32'h0;
    for (int i = 0; i < 10 && pend[0]; i++) step(1'b0);
    drain();

    // All requesters continuously from reset: 0,1,2,3,0,... every 3 cycles.
    for (int i = 0; i < NR; i++) new_req(i);
    cont = 1'b1;
    step(1'b1);
    for (int i = 0; i < 16; i++) step(1'b0);
    cont = 1'b0;
    drain();

    // Pointer wrap: leave pointer at 3, then requests on 1 and 3.
    step(1'b1);
    pend[2] = 1'b1; pwr[2] = 1'b0;
    for (int i = 0; i < 10 && pend[2]; i++) step(1'b0);
    drain();
    new_req(1);
    new_req(3);
    for (int i = 0; i < 10; i++) step(1'b0);
    drain();

    // Random traffic with occasional withdrawals.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) new_req(i);
        else if (pend[i] && $urandom_range(0, 63) == 0) pend[i] = 1'b0;
      end
      step(1'b0);
    end
    drain();

    // One-cycle accessError: sticky until reset.
    force_req = 1'b1;
    step(1'b0);
    force_req = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 2; i++) step(1'b0);

    // Reset during ISSUE of a write; requester 0 must win right after reset.
    pend[1] = 1'b1; pwr[1] = 1'b1; pdat[1] = 32'h12345678;
    for (int i = 0; i < 10 && pend[1]; i++) step(1'b0);
    new_req(0);
    new_req(2);
    step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
